// File: rtl/tdc_shot_sequencer.sv
// tdc_shot_sequencer: frame controller issuing N periodic tdc_start shots, then collecting one histogram result.
// Ports: clk_i/rst (async, active-low); cfg_period/cfg_shots/cmd_start/cmd_abort from core;
// busy, tdc_start to TDC; his_en/his_ibatch/his_odata/his_ovalid/his_oready to histogram;
// frame_data/frame_valid/frame_ready/frame_timeout result handshake to core.
// Optional result-wait watchdog enabled by defining TDC_SEQ_TIMEOUT_EN.
module tdc_shot_sequencer #(
    parameter int PERIOD_W = 20,
    parameter int SHOT_W   = 16,
    parameter int DATA_W   = 15,
    parameter int TIMEOUT  = 4096
) (
    input  logic                clk_i,
    input  logic                rst,
    input  logic [PERIOD_W-1:0] cfg_period,
    input  logic [SHOT_W-1:0]   cfg_shots,
    input  logic                cmd_start,
    input  logic                cmd_abort,
    output logic                busy,
    output logic                tdc_start,
    output logic                his_en,
    output logic [SHOT_W-1:0]   his_ibatch,
    input  logic [DATA_W-1:0]   his_odata,
    input  logic                his_ovalid,
    output logic                his_oready,
    output logic [DATA_W-1:0]   frame_data,
    output logic                frame_valid,
    input  logic                frame_ready,
    output logic                frame_timeout
);
    typedef enum logic [1:0] {IDLE, SHOOT, WAIT_RES, OUT} state_t;
    state_t state;
    logic [PERIOD_W-1:0] per_last, cnt, cnt_nxt;
    logic [SHOT_W-1:0] shots;
    assign cnt_nxt = (cnt == per_last) ? '0 : cnt + 1'b1;
`ifdef TDC_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] wd;
`else
    assign frame_timeout = 1'b0;
`endif
    always_ff @(posedge clk_i or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            tdc_start   <= 1'b0;
            his_en      <= 1'b0;
            his_oready  <= 1'b0;
            his_ibatch  <= '0;
            frame_data  <= '0;
            frame_valid <= 1'b0;
            per_last    <= '0;
            cnt         <= '0;
            shots       <= '0;
`ifdef TDC_SEQ_TIMEOUT_EN
            frame_timeout <= 1'b0;
            wd            <= '0;
`endif
        end else if (cmd_abort) begin
            state       <= IDLE;
            busy        <= 1'b0;
            tdc_start   <= 1'b0;
            his_en      <= 1'b0;
            his_oready  <= 1'b0;
            frame_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: if (cmd_start && cfg_shots != '0) begin
                    state      <= SHOOT;
                    per_last   <= (cfg_period < PERIOD_W'(2)) ? PERIOD_W'(1) : cfg_period - 1'b1;
                    his_ibatch <= cfg_shots;
                    cnt        <= '0;
                    shots      <= SHOT_W'(1);
                    tdc_start  <= 1'b1;
                    busy       <= 1'b1;
                    his_en     <= 1'b1;
                end
                // A pulse goes out on each counter wrap until N have been issued;
                // the wrap after the last pulse's period hands over to WAIT_RES.
                SHOOT: begin
                    cnt       <= cnt_nxt;
                    tdc_start <= (cnt_nxt == '0) && (shots != his_ibatch);
                    if (cnt_nxt == '0) begin
                        if (shots == his_ibatch) begin
                            state      <= WAIT_RES;
                            his_oready <= 1'b1;
`ifdef TDC_SEQ_TIMEOUT_EN
                            wd         <= '0;
`endif
                        end else begin
                            shots <= shots + 1'b1;
                        end
                    end
                end
                WAIT_RES: if (his_ovalid && his_oready) begin
                    state       <= OUT;
                    frame_data  <= his_odata;
                    frame_valid <= 1'b1;
                    his_oready  <= 1'b0;
                    his_en      <= 1'b0;
`ifdef TDC_SEQ_TIMEOUT_EN
                    frame_timeout <= 1'b0;
                end else if (wd == TW'(TIMEOUT - 1)) begin
                    state         <= OUT;
                    frame_data    <= '1;
                    frame_timeout <= 1'b1;
                    frame_valid   <= 1'b1;
                    his_oready    <= 1'b0;
                    his_en        <= 1'b0;
                end else begin
                    wd <= wd + 1'b1;
`endif
                end
                OUT: if (frame_ready) begin
                    state       <= IDLE;
                    frame_valid <= 1'b0;
                    busy        <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tdc_shot_sequencer.sv
// tb_tdc_shot_sequencer: scoreboard bench for tdc_shot_sequencer (pulse times and frame results).
module tb_tdc_shot_sequencer;
    localparam int PW = 20, SW = 16, DW = 15, TO = 100;
    logic clk = 1'b0, rst = 1'b0;
    logic [PW-1:0] cfg_period = '0;
    logic [SW-1:0] cfg_shots = '0;
    logic cmd_start = 1'b0, cmd_abort = 1'b0, his_ovalid = 1'b0, frame_ready = 1'b0;
    logic [DW-1:0] his_odata = '0;
    logic busy, tdc_start, his_en, his_oready, frame_valid, frame_timeout;
    logic [SW-1:0] his_ibatch;
    logic [DW-1:0] frame_data;

    tdc_shot_sequencer #(.PERIOD_W(PW), .SHOT_W(SW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk_i(clk), .rst(rst), .cfg_period(cfg_period), .cfg_shots(cfg_shots),
        .cmd_start(cmd_start), .cmd_abort(cmd_abort), .busy(busy), .tdc_start(tdc_start),
        .his_en(his_en), .his_ibatch(his_ibatch), .his_odata(his_odata), .his_ovalid(his_ovalid),
        .his_oready(his_oready), .frame_data(frame_data), .frame_valid(frame_valid),
        .frame_ready(frame_ready), .frame_timeout(frame_timeout)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0, cyc = 0;
    int exp_pulse[$];
    logic [DW:0] exp_frames[$];
    int e0, pe, cur_n;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h required %0h (edge %0d)", nm, act, exp, cyc);
        end
    endtask

    // Outputs seen here were set by edge cyc; inputs seen here are sampled at edge cyc+1.
    always @(negedge clk) if (rst) begin
        if (tdc_start) begin
            if (exp_pulse.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL pulse: tdc_start at edge %0d, required none", cyc);
            end else chk("pulse_edge", cyc, exp_pulse.pop_front());
        end
        if (frame_valid && frame_ready) begin
            if (exp_frames.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL frame: result %0h accepted, required none", frame_data);
            end else chk("frame", {frame_timeout, frame_data}, exp_frames.pop_front());
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_start(input int p, input int n);
        pe = (p < 2) ? 2 : p;
        cur_n = n;
        cfg_period = PW'(p);
        cfg_shots = SW'(n);
        cmd_start = 1'b1;
        e0 = cyc + 1;
        for (int k = 0; k < n; k++) exp_pulse.push_back(e0 + k * pe);
        tick();
        cmd_start = 1'b0;
    endtask

    task automatic wait_res();
        for (int i = 0; i < cur_n * pe + 10 && !his_oready; i++) tick();
        chk("wait_res_entry", cyc, e0 + cur_n * pe);
        chk("his_en_wait", his_en, 1);
    endtask

    task automatic give(input int dly, input logic [DW-1:0] d);
        repeat (dly) tick();
        his_odata = d;
        his_ovalid = 1'b1;
        exp_frames.push_back({1'b0, d});
        tick();
        his_ovalid = 1'b0;
        chk("frame_valid_set", frame_valid, 1);
        chk("oready_out", his_oready, 0);
    endtask

    task automatic accept(input int dly);
        repeat (dly) tick();
        frame_ready = 1'b1;
        tick();
        frame_ready = 1'b0;
        chk("frame_valid_clr", frame_valid, 0);
        chk("busy_clr", busy, 0);
    endtask

    initial begin
        logic [DW-1:0] held;
        logic stable;
        int ea;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_outs", {busy, tdc_start, his_en, his_oready, frame_valid, frame_timeout}, 0);
        chk("rst_data", {frame_data, his_ibatch}, 0);
        rst = 1'b1;
        tick();

        // main directed frame
        do_start(640, 10);
        chk("busy_start", {busy, his_en, tdc_start}, 3'b111);
        chk("ibatch", his_ibatch, 10);
        wait_res();
        give(0, 15'd1234);
        accept(3);

        // zero shots rejected
        do_start(5, 0);
        repeat (3) tick();
        chk("zero_shots_busy", {busy, his_en}, 0);

        // period clamp: pulses 2 apart
        do_start(1, 3);
        wait_res();
        give(2, 15'h2AAA);
        accept(0);

        // abort at shot 4
        do_start(7, 10);
        while (cyc < e0 + 3 * pe) tick();
        cmd_abort = 1'b1;
        ea = cyc + 1;
        while (exp_pulse.size() != 0 && exp_pulse[$] >= ea) void'(exp_pulse.pop_back());
        tick();
        cmd_abort = 1'b0;
        chk("abort_outs", {busy, tdc_start, his_en, his_oready, frame_valid}, 0);
        repeat (80) tick();
        chk("abort_noframe", frame_valid, 0);

        // simultaneous start and abort in idle
        cfg_shots = 5;
        cmd_start = 1'b1;
        cmd_abort = 1'b1;
        tick();
        cmd_start = 1'b0;
        cmd_abort = 1'b0;
        repeat (3) tick();
        chk("start_abort_idle", busy, 0);

        // stray his_ovalid during SHOOT, then held result while start is ignored
        do_start(5, 4);
        tick();
        his_odata = 15'h1111;
        his_ovalid = 1'b1;
        chk("oready_shoot", his_oready, 0);
        tick();
        his_ovalid = 1'b0;
        wait_res();
        give(1, 15'h0F0F);
        held = frame_data;
        stable = 1'b1;
        cfg_shots = 3;
        cmd_start = 1'b1;
        repeat (50) begin
            tick();
            stable &= (frame_data == held) && frame_valid && busy;
        end
        cmd_start = 1'b0;
        chk("hold_stable", stable, 1);
        accept(0);

        // abort in OUT discards result
        do_start(3, 2);
        wait_res();
        give(0, 15'h7123);
        void'(exp_frames.pop_back());
        cmd_abort = 1'b1;
        tick();
        cmd_abort = 1'b0;
        chk("abort_out", {frame_valid, busy}, 0);

        // back-to-back: start on accept edge ignored, next cycle accepted
        do_start(4, 2);
        wait_res();
        give(0, 15'h0055);
        frame_ready = 1'b1;
        cmd_start = 1'b1;
        cfg_period = 3;
        cfg_shots = 2;
        tick();
        frame_ready = 1'b0;
        chk("b2b_not_sampled", busy, 0);
        do_start(3, 2);
        chk("b2b_started", busy, 1);
        wait_res();
        give(0, 15'h0066);
        accept(1);

        // result wait without handshake
        do_start(3, 2);
        wait_res();
`ifdef TDC_SEQ_TIMEOUT_EN
        exp_frames.push_back({1'b1, {DW{1'b1}}});
        repeat (TO - 1) tick();
        chk("to_not_yet", frame_valid, 0);
        tick();
        chk("to_fired", {frame_valid, frame_timeout, frame_data}, {2'b11, {DW{1'b1}}});
        accept(2);
`else
        repeat (150) tick();
        chk("no_timeout", {his_oready, busy, frame_valid, frame_timeout}, 4'b1100);
        give(0, 15'h4321);
        accept(0);
`endif

        // randomized frames
        for (int f = 0; f < 25; f++) begin
            do_start($urandom_range(0, 12), $urandom_range(1, 6));
            wait_res();
            give($urandom_range(0, 5), DW'($urandom_range(0, 32767)));
            accept($urandom_range(0, 5));
        end

        // async reset mid-SHOOT
        do_start(4, 50);
        repeat (10) tick();
        #1 rst = 1'b0;
        #1;
        chk("arst_outs", {busy, tdc_start, his_en, his_oready, frame_valid, frame_timeout}, 0);
        chk("arst_data", {frame_data, his_ibatch}, 0);
        exp_pulse.delete();
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        tick();
        chk("arst_idle", busy, 0);
        do_start(2, 3);
        wait_res();
        give(0, 15'h0123);
        accept(0);

        repeat (5) tick();
        chk("pulses_left", exp_pulse.size(), 0);
        chk("frames_left", exp_frames.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/tdc_shot_sequencer.md
# tdc_shot_sequencer

Frame-level controller for the TDC + histogram datapath. It issues a programmed number of one-cycle `tdc_start` shots at a fixed period, keeps the histogram enabled and configured for that batch, then collects the histogram's peak-depth result over a valid/ready handshake and presents it as one frame result. It sits between core logic (command/result side) and the `tdc_top`/`histogram` pair, replacing free-running start-pulse generation.

## Interface
- `PERIOD_W`, 20, width of shot-period configuration
- `SHOT_W`, 16, width of shots-per-frame count (matches `HIS_Ibatch`)
- `DATA_W`, 15, depth data width (matches `HIS_Odata`)
- `TIMEOUT`, 4096, result-wait watchdog limit in clk_i cycles (used only with `TDC_SEQ_TIMEOUT_EN`)

Reset rst, asynchronous, active-low; clock clk_i.
- `clk_i`  input  1  logic clock
- `rst`  input  1  asynchronous reset, active-low
- `cfg_period`  input  PERIOD_W  clk_i cycles between shots; values <2 treated as 2
- `cfg_shots`  input  SHOT_W  shots per frame; 0 = command rejected
- `cmd_start`  input  1  frame start request, sampled in IDLE only
- `cmd_abort`  input  1  abort current frame, any state
- `busy`  output  1  high in any state except IDLE
- `tdc_start`  output  1  registered one-cycle shot pulse to TDC
- `his_en`  output  1  histogram enable; high in SHOOT and WAIT_RES
- `his_ibatch`  output  SHOT_W  latched shot count for histogram
- `his_odata`  input  DATA_W  histogram result
- `his_ovalid`  input  1  histogram result valid
- `his_oready`  output  1  high only in WAIT_RES
- `frame_data`  output  DATA_W  captured frame result
- `frame_valid`  output  1  frame result valid, held until accepted
- `frame_ready`  input  1  core accepts frame result
- `frame_timeout`  output  1  qualifies `frame_data` as a timeout marker

## Operation
- States: IDLE, SHOOT, WAIT_RES, OUT.
- IDLE: on `cmd_start`=1, `cmd_abort`=0 and `cfg_shots`≠0, latch period P (clamped ≥2) and shot count N into `his_ibatch`, go SHOOT. `cfg_shots`=0 → stay IDLE, no output change.
- SHOOT: period counter runs 0..P-1 and wraps; `tdc_start` asserted for the cycle following every counter value 0; shot counter increments per pulse. After pulse N, counter finishes that period; on wrap go WAIT_RES. No further pulses.
- WAIT_RES: `his_oready`=1. On `his_ovalid & his_oready` capture `his_odata` into `frame_data`, `frame_timeout`=0, go OUT.
- OUT: `frame_valid`=1, data stable; on `frame_ready` go IDLE, `frame_valid`→0.
- `cmd_abort`: from any state, next edge → IDLE; `tdc_start`, `his_en`, `his_oready`, `frame_valid` cleared; no frame produced; abort wins over simultaneous `cmd_start`. Abort in OUT discards unaccepted result.
- `cmd_start` while busy ignored; `cfg_*` changes mid-frame have no effect.
- Counters sized to their config widths; no overflow possible since they reset per frame.

## Timing
- Reset values: `busy`, `tdc_start`, `his_en`, `his_oready`, `frame_valid`, `frame_timeout` = 0; `frame_data`, `his_ibatch` = 0; state IDLE.
- Edge E0 samples `cmd_start`: `busy`, `his_en`, `tdc_start` high after E0.
- Shot k (0-based) pulse high in cycle after edge E0+k·P; exactly N pulses, each 1 cycle.
- WAIT_RES entered at edge E0+N·P; `his_oready` high from that edge; `his_en` stays high.
- Result captured on handshake edge Eh; `frame_valid` high after Eh; earliest Eh = E0+N·P+1.
- `his_ovalid` outside WAIT_RES ignored (not captured, `his_oready`=0).
- Back-to-back frames: `cmd_start` on same edge `frame_ready` accepts → not sampled (state still OUT); next cycle onward accepted.

## Configuration
- `TDC_SEQ_TIMEOUT_EN` defined: WAIT_RES counts cycles; on reaching `TIMEOUT` without handshake go OUT with `frame_data`=all ones (15'h7FFF), `frame_timeout`=1. Handshake on the timeout edge takes priority (real data captured).
- Undefined: WAIT_RES waits indefinitely; `frame_timeout` tied 0; no watchdog counter.

## Test plan
- P=640, N=10, cmd_start at E0 → 10 pulses at E0+0,640,…,5760; WAIT_RES at E0+6400; his_odata=15'd1234 with his_ovalid → frame_data=1234, frame_valid until frame_ready.
- cfg_shots=0 with cmd_start → busy stays 0, no tdc_start; cfg_period=1, N=3 → pulses 2 cycles apart.
- cmd_abort at shot 4 of N=10 → IDLE next edge, no further pulses, no frame_valid; simultaneous cmd_start+cmd_abort in IDLE → stays IDLE.
- frame_ready held low 50 cycles in OUT → frame_data stable, new cmd_start ignored; his_ovalid pulsed during SHOOT → not captured.
- With TDC_SEQ_TIMEOUT_EN, TIMEOUT=100, his_ovalid never asserted → at 100 cycles in WAIT_RES frame_data=7FFF, frame_timeout=1; without macro → remains WAIT_RES.
- Async rst asserted mid-SHOOT → all outputs 0 immediately, IDLE after release.
